// File: rtl/crate_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : crate_write_arbiter
// Brief    : Round-robin arbiter that frames 3-byte crate records into a DMA
//            write buffer, launches the transfer and waits for completion.
// Revision : 1.0 - initial release
// ============================================================================
module crate_write_arbiter #(
  parameter logic [31:0] BASE_ADDR    = 32'h10004000,
  parameter int          GAP_CYCLES   = 16,
  parameter int          DONE_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [19:0] req_module,
  input  logic [7:0]  req_port,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic        err,
  output logic        busy,
  output logic        control_fixed,
  output logic        control_go,
  output logic [31:0] control_write_base,
  output logic [31:0] control_write_length,
  input  logic        control_done,
  output logic [7:0]  user_buffer_input,
  output logic        user_write_buffer,
  input  logic        user_buffer_full
);

  localparam int             TMO_W    = $clog2(DONE_TIMEOUT + 1);
  localparam int             GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(DONE_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B0   = 3'd1,
    B1   = 3'd2,
    B2   = 3'd3,
    GO   = 3'd4,
    WAIT = 3'd5,
    GAP  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       idx_q, idx_d;
  logic [4:0]       mod_q, mod_d;
  logic [1:0]       port_q, port_d;
  logic [7:0]       data_q, data_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic [1:0] cand;
  logic [4:0] mod_arr  [4];
  logic [1:0] port_arr [4];
  logic [7:0] data_arr [4];

  assign control_fixed        = 1'b0;
  assign control_write_base   = BASE_ADDR;
  assign control_write_length = 32'd3;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      mod_arr[i]  = req_module[5*i +: 5];
      port_arr[i] = req_port[2*i +: 2];
      data_arr[i] = req_data[8*i +: 8];
    end
  end

  // Scan downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr_q + 2'(k);
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    mod_d    = mod_q;
    port_d   = port_q;
    data_d   = data_q;
    tmo_d    = '0;
    gap_d    = '0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d  = B0;
          idx_d    = gnt_idx;
          mod_d    = mod_arr[gnt_idx];
          port_d   = port_arr[gnt_idx];
          data_d   = data_arr[gnt_idx];
          rr_ptr_d = gnt_idx + 2'd1;
        end
      end
      B0:   if (!user_buffer_full) state_d = B1;
      B1:   if (!user_buffer_full) state_d = B2;
      B2:   if (!user_buffer_full) state_d = GO;
      GO:   state_d = WAIT;
      WAIT: begin
        if (control_done || tmo_q == TMO_MAX) begin
          state_d = GAP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced to their idle values for the whole reset cycle,
  // even though the state register only clears at the following edge.
  always_comb begin
    ack               = '0;
    err               = 1'b0;
    busy              = 1'b0;
    control_go        = 1'b0;
    user_buffer_input = '0;
    user_write_buffer = 1'b0;
    if (!reset) begin
      busy       = (state_q != IDLE);
      control_go = (state_q == GO);
      if (state_q == WAIT) begin
        if (control_done)          ack = 4'b0001 << idx_q;
        else if (tmo_q == TMO_MAX) err = 1'b1;
      end
      case (state_q)
        B0:      user_buffer_input = {3'b000, mod_q};
        B1:      user_buffer_input = {6'b000000, port_q};
        B2:      user_buffer_input = data_q;
        default: user_buffer_input = '0;
      endcase
      user_write_buffer = (state_q == B0 || state_q == B1 || state_q == B2) && !user_buffer_full;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      mod_q    <= '0;
      port_q   <= '0;
      data_q   <= '0;
      tmo_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      mod_q    <= mod_d;
      port_q   <= port_d;
      data_q   <= data_d;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_crate_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_crate_write_arbiter
// Brief    : Directed vector table plus multi-cycle sequences for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crate_write_arbiter;

  localparam logic [31:0] BASE = 32'h10004000;
  localparam int          GAP  = 4;
  localparam int          TMO  = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [19:0] req_module = '0;
  logic [7:0]  req_port = '0;
  logic [31:0] req_data = '0;
  logic        control_done = 1'b0;
  logic        user_buffer_full = 1'b0;
  logic [3:0]  ack;
  logic        err, busy, control_fixed, control_go, user_write_buffer;
  logic [31:0] control_write_base, control_write_length;
  logic [7:0]  user_buffer_input;

  int checks = 0;
  int fails  = 0;
  int cyc_n  = 0;

  crate_write_arbiter #(.BASE_ADDR(BASE), .GAP_CYCLES(GAP), .DONE_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_module(req_module), .req_port(req_port),
    .req_data(req_data), .ack(ack), .err(err), .busy(busy), .control_fixed(control_fixed),
    .control_go(control_go), .control_write_base(control_write_base),
    .control_write_length(control_write_length), .control_done(control_done),
    .user_buffer_input(user_buffer_input), .user_write_buffer(user_write_buffer),
    .user_buffer_full(user_buffer_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [19:0] mod;
    logic [7:0]  port;
    logic [31:0] data;
    logic        full;
    logic        done;
    logic [3:0]  e_ack;
    logic        e_err;
    logic        e_busy;
    logic        e_go;
    logic        e_wb;
    logic [7:0]  e_byte;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    control_done = 1'b0;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b1;
    req   = '0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [19:0] m, input logic [7:0] p,
                     input logic [31:0] d, input logic f, input logic dn, input logic [3:0] ea,
                     input logic ee, input logic eb, input logic eg, input logic ew, input logic [7:0] ey);
    vec_t v;
    v.rst = r; v.req = rq; v.mod = m; v.port = p; v.data = d; v.full = f; v.done = dn;
    v.e_ack = ea; v.e_err = ee; v.e_busy = eb; v.e_go = eg; v.e_wb = ew; v.e_byte = ey;
    vq.push_back(v);
  endtask

  // Runs one record to its ack or err; done is raised dly cycles after go (never if dly<0).
  task automatic rec(input int dly, input logic [31:0] d_b1, input logic [31:0] d_wait,
                     output logic [3:0] a, output logic e, output logic [7:0] b0, output logic [7:0] b1,
                     output logic [7:0] b2, output int t_first, output int t_go, output int t_end);
    int  nb = 0;
    int  cnt = 0;
    bit  go_seen = 0;
    bit  fin = 0;
    bit  viol = 0;
    a = '0; e = 1'b0; b0 = '0; b1 = '0; b2 = '0; t_first = -1; t_go = -1; t_end = -1;
    for (int n = 0; n < 200 && !fin; n++) begin
      cyc();
      control_done = go_seen && dly >= 0 && cnt == dly;
      if (nb == 1) req_data = d_b1;
      if (go_seen) req_data = d_wait;
      #1;
      if (user_write_buffer) begin
        case (nb)
          0: begin b0 = user_buffer_input; t_first = cyc_n; end
          1: b1 = user_buffer_input;
          2: b2 = user_buffer_input;
          default: viol = 1;
        endcase
        nb++;
      end
      if (control_go) begin go_seen = 1; cnt = 1; t_go = cyc_n; end
      else if (go_seen) cnt++;
      if ((ack != 0 && err) || $countones(ack) > 1) viol = 1;
      if (ack != 0 || err) begin a = ack; e = err; t_end = cyc_n; fin = 1; end
    end
    chk("record_completes", 32'(fin), 32'd1);
    chk("ack_err_exclusive", 32'(viol), 32'd0);
  endtask

  localparam logic [19:0] M1 = 20'h00001;
  localparam logic [19:0] M2 = 20'h003E0;
  localparam logic [31:0] D1 = 32'h000000A5;
  localparam logic [31:0] D2 = 32'h00003C00;

  initial begin
    logic [3:0] a;
    logic       e;
    logic [7:0] b0, b1, b2;
    int         tf, tg, te, prev_end;
    logic [3:0] ack_acc;

    // Single request, then a stalled port byte with an early stray control_done.
    add(1, 4'h0, M1, 8'h00, D1, 0, 0, 4'h0, 0, 0, 0, 0, 8'h00);
    add(1, 4'h1, M1, 8'h00, D1, 0, 0, 4'h0, 0, 0, 0, 0, 8'h00);
    add(0, 4'h1, M1, 8'h00, D1, 0, 0, 4'h0, 0, 0, 0, 0, 8'h00);
    add(0, 4'h1, M1, 8'h00, D1, 0, 0, 4'h0, 0, 1, 0, 1, 8'h01);
    add(0, 4'h1, M1, 8'h00, D1, 0, 0, 4'h0, 0, 1, 0, 1, 8'h00);
    add(0, 4'h1, M1, 8'h00, D1, 0, 0, 4'h0, 0, 1, 0, 1, 8'hA5);
    add(0, 4'h1, M1, 8'h00, D1, 0, 0, 4'h0, 0, 1, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) add(0, 4'h1, M1, 8'h00, D1, 0, 0, 4'h0, 0, 1, 0, 0, 8'h00);
    add(0, 4'h1, M1, 8'h00, D1, 0, 1, 4'h1, 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < GAP; i++) add(0, 4'h0, M1, 8'h00, D1, 0, 0, 4'h0, 0, 1, 0, 0, 8'h00);
    add(0, 4'h0, M1, 8'h00, D1, 0, 0, 4'h0, 0, 0, 0, 0, 8'h00);
    add(0, 4'h2, M2, 8'h0C, D2, 0, 0, 4'h0, 0, 0, 0, 0, 8'h00);
    add(0, 4'h2, M2, 8'h0C, D2, 0, 1, 4'h0, 0, 1, 0, 1, 8'h1F);
    for (int i = 0; i < 3; i++) add(0, 4'h2, M2, 8'h0C, D2, 1, 0, 4'h0, 0, 1, 0, 0, 8'h03);
    add(0, 4'h2, M2, 8'h0C, D2, 0, 0, 4'h0, 0, 1, 0, 1, 8'h03);
    add(0, 4'h2, M2, 8'h0C, D2, 0, 0, 4'h0, 0, 1, 0, 1, 8'h3C);
    add(0, 4'h2, M2, 8'h0C, D2, 0, 0, 4'h0, 0, 1, 1, 0, 8'h00);
    add(0, 4'h2, M2, 8'h0C, D2, 0, 1, 4'h2, 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < GAP; i++) add(0, 4'h0, M2, 8'h0C, D2, 0, 0, 4'h0, 0, 1, 0, 0, 8'h00);
    add(0, 4'h0, M2, 8'h0C, D2, 0, 0, 4'h0, 0, 0, 0, 0, 8'h00);

    foreach (vq[i]) begin
      cyc();
      reset = vq[i].rst; req = vq[i].req; req_module = vq[i].mod; req_port = vq[i].port;
      req_data = vq[i].data; user_buffer_full = vq[i].full; control_done = vq[i].done;
      #1;
      chk($sformatf("v%0d_ack", i),  32'(ack),               32'(vq[i].e_ack));
      chk($sformatf("v%0d_err", i),  32'(err),               32'(vq[i].e_err));
      chk($sformatf("v%0d_busy", i), 32'(busy),              32'(vq[i].e_busy));
      chk($sformatf("v%0d_go", i),   32'(control_go),        32'(vq[i].e_go));
      chk($sformatf("v%0d_wb", i),   32'(user_write_buffer), 32'(vq[i].e_wb));
      chk($sformatf("v%0d_byte", i), 32'(user_buffer_input), 32'(vq[i].e_byte));
      chk($sformatf("v%0d_fixed", i), 32'(control_fixed),    32'd0);
      chk($sformatf("v%0d_base", i), control_write_base,     BASE);
      chk($sformatf("v%0d_len", i),  control_write_length,   32'd3);
    end
    user_buffer_full = 1'b0;

    // All four requesting continuously: order 0,1,2,3,0 with GAP idle cycles between.
    do_reset();
    req_module = {5'd4, 5'd3, 5'd2, 5'd1};
    req_port   = 8'h00;
    req_data   = 32'h44332211;
    req        = 4'hF;
    prev_end   = -1;
    for (int k = 0; k < 5; k++) begin
      rec(1, req_data, req_data, a, e, b0, b1, b2, tf, tg, te);
      chk($sformatf("rr%0d_ack", k), 32'(a), 32'(4'b0001 << (k % 4)));
      chk($sformatf("rr%0d_module", k), 32'(b0), 32'((k % 4) + 1));
      if (k > 0) chk($sformatf("rr%0d_gap", k), tf - prev_end, GAP + 2);
      prev_end = te;
    end

    // Timeout: done never comes for requester 2, then the held request is serviced again.
    do_reset();
    req = 4'b0100;
    rec(-1, req_data, req_data, a, e, b0, b1, b2, tf, tg, te);
    chk("tmo_err", 32'(e), 32'd1);
    chk("tmo_no_ack", 32'(a), 32'd0);
    chk("tmo_latency", te - tg, TMO + 1);
    prev_end = te;
    rec(2, req_data, req_data, a, e, b0, b1, b2, tf, tg, te);
    chk("tmo_retry_gap", tf - prev_end, GAP + 2);
    chk("tmo_retry_ack", 32'(a), 32'h4);
    chk("tmo_retry_no_err", 32'(e), 32'd0);

    // Reset asserted while in B2 abandons the record; it is re-sent from B0.
    do_reset();
    ack_acc = '0;
    req = 4'b0001; req_module = 20'h00002; req_port = 8'h01; req_data = 32'h00000077;
    #1; chk("rst_idle_busy", 32'(busy), 32'd0); ack_acc |= ack;
    cyc(); #1; chk("rst_b0_byte", 32'(user_buffer_input), 32'h02); ack_acc |= ack;
    cyc(); #1; chk("rst_b1_byte", 32'(user_buffer_input), 32'h01); ack_acc |= ack;
    cyc(); reset = 1'b1; #1;
    chk("rst_in_b2_wb", 32'(user_write_buffer), 32'd0);
    chk("rst_in_b2_byte", 32'(user_buffer_input), 32'd0);
    chk("rst_in_b2_busy", 32'(busy), 32'd0);
    ack_acc |= ack;
    cyc(); reset = 1'b0; #1;
    chk("rst_after_busy", 32'(busy), 32'd0);
    chk("rst_after_wb", 32'(user_write_buffer), 32'd0);
    ack_acc |= ack;
    chk("rst_no_ack", 32'(ack_acc), 32'd0);
    cyc(); #1;
    chk("rst_resend_b0", 32'(user_buffer_input), 32'h02);
    chk("rst_resend_wb", 32'(user_write_buffer), 32'd1);
    rec(1, req_data, req_data, a, e, b0, b1, b2, tf, tg, te);
    chk("rst_resend_ack", 32'(a), 32'h1);
    chk("rst_resend_data", 32'(b1), 32'h77);

    // Captured data is immune to req_data changes; the next record carries the new value.
    req_data = 32'h00000011;
    rec(2, 32'h00000033, 32'h00000022, a, e, b0, b1, b2, tf, tg, te);
    chk("dchg_first_data", 32'(b2), 32'h11);
    chk("dchg_first_ack", 32'(a), 32'h1);
    rec(1, req_data, req_data, a, e, b0, b1, b2, tf, tg, te);
    chk("dchg_next_data", 32'(b2), 32'h22);
    chk("dchg_next_ack", 32'(a), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crate_write_arbiter.md
CRATE_WRITE_ARBITER -- requirements
Module: crate_write_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- BASE_ADDR, 32'h10004000, DMA write base address.
- GAP_CYCLES, 16, idle cycles enforced between records.
- DONE_TIMEOUT, 1024, maximum cycles to wait for control_done.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, synchronous active-high reset.
- req, in, 4, per-requester write request, level, held until ack.
- req_module, in, 20, 5-bit module number per requester; requester i uses bits [5i+4:5i].
- req_port, in, 8, 2-bit port per requester; requester i uses bits [2i+1:2i].
- req_data, in, 32, 8-bit data per requester; requester i uses bits [8i+7:8i].
- ack, out, 4, one-cycle completion pulse to the granted requester.
- err, out, 1, one-cycle pulse on done timeout.
- busy, out, 1, high whenever state is not IDLE.
- control_fixed, out, 1, DMA fixed-address control, constant 0.
- control_go, out, 1, DMA start pulse.
- control_write_base, out, 32, constant BASE_ADDR.
- control_write_length, out, 32, constant 3 (bytes per record).
- control_done, in, 1, DMA transfer-complete indication.
- user_buffer_input, out, 8, byte to the DMA write buffer.
- user_write_buffer, out, 1, buffer write qualifier.
- user_buffer_full, in, 1, buffer cannot accept a byte this cycle.

Function
REQ-004 State machine states SHALL be IDLE, B0, B1, B2, GO, WAIT, GAP.
REQ-005 In IDLE with any req bit set, the block SHALL grant one requester by round-robin, starting the search at rr_ptr, and move to B0 on the next cycle.
REQ-006 At grant, the block SHALL capture the granted index and its module, port and data into registers; later changes on the req_* inputs SHALL NOT affect the record in flight.
REQ-007 After each grant to index i, rr_ptr SHALL become (i+1) mod 4; rr_ptr SHALL reset to 0.
REQ-008 In B0, B1 and B2, user_buffer_input SHALL present {3'b0,module}, {6'b0,port} and data respectively, with user_write_buffer=1 only in cycles where user_buffer_full=0.
REQ-009 A byte state SHALL advance only in a cycle where it wrote (user_buffer_full=0); while user_buffer_full=1 the state and byte SHALL hold and user_write_buffer SHALL be 0.
REQ-010 GO SHALL assert control_go for exactly one cycle and then enter WAIT.
REQ-011 In WAIT, control_done=1 SHALL pulse ack[granted] for one cycle and enter GAP.
REQ-012 In WAIT, a timeout counter SHALL count cycles. On reaching DONE_TIMEOUT without control_done, the block SHALL pulse err for one cycle, issue no ack, and enter GAP.
REQ-013 If control_done and timeout coincide, the block SHALL treat it as done: ack, no err.
REQ-014 GAP SHALL last GAP_CYCLES cycles and then return to IDLE.
REQ-015 Requests present during GAP SHALL be ignored until IDLE; a requester's req deasserting before grant SHALL simply drop it.
REQ-016 control_done asserted outside WAIT SHALL be ignored.
REQ-017 Counters SHALL be sized ceil(log2(param+1)) bits and SHALL never wrap.
REQ-018 At most one ack bit SHALL be high in any cycle; ack and err SHALL never be high together.
REQ-019 Minimum record latency, from grant to ack, SHALL be 5 cycles plus the control_done delay.

Reset
REQ-020 While reset=1, the outputs SHALL be: state IDLE, control_go=0, user_write_buffer=0, user_buffer_input=0, ack=0, err=0, busy=0, rr_ptr=0, counters=0.
REQ-021 Reset SHALL take effect in any state, mid-record included; the partial record SHALL be abandoned with no ack.
REQ-022 control_fixed, control_write_base and control_write_length SHALL hold their constant values in and out of reset.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Single request: req=0001, module=1, port=0, data=8'hA5 -> bytes 01,00,A5 on three consecutive cycles; control_go one cycle later; control_done 4 cycles after that -> ack=0001.
- All four requesting continuously -> grant order 0,1,2,3,0; at least GAP_CYCLES idle cycles between each record.
- user_buffer_full high for 3 cycles during B1 -> port byte held, user_write_buffer=0 for those cycles, then written once; no byte duplicated or lost.
- control_done never asserted -> err pulse exactly DONE_TIMEOUT cycles after entering WAIT; no ack; next request serviced after GAP.
- Reset asserted in B2 -> next cycle IDLE, all outputs at reset values; the re-presented request is re-sent from B0.
- req_data changed during WAIT -> the already-sent record is unaffected; the next record carries the new value.
